// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one 32-bit read or write per command, valid/ready
// command and response handshakes, and a watchdog that aborts unacknowledged cycles.
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i
);

  localparam bit               LP_TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LP_TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_cyc, w_cyc_nxt;
  logic             r_we, w_we_nxt;
  logic [3:0]       r_sel, w_sel_nxt;
  logic [31:0]      r_adr, w_adr_nxt;
  logic [31:0]      r_wdat, w_wdat_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]      r_rsp_dat, w_rsp_dat_nxt;
  logic             r_rsp_err, w_rsp_err_nxt;
  logic             w_tmo;

  // Watchdog fires on the last permitted stb cycle; an ack in that cycle still wins.
  assign w_tmo = LP_TMO_EN && (r_cnt == LP_TMO_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_wdat_nxt      = r_wdat;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_we_nxt    = cmd_we;
          w_sel_nxt   = cmd_sel;
          w_adr_nxt   = cmd_adr;
          w_wdat_nxt  = cmd_dat;
          w_cyc_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbs_ack_i) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = r_we ? 32'h0 : wbs_dat_i;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else if (w_tmo) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = 32'h0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_cyc_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_adr       <= 32'h0;
      r_wdat      <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_wdat      <= w_wdat_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Classic single transfers: stb always tracks cyc.
  assign cmd_ready = (r_state == ST_IDLE);
  assign wbs_cyc_o = r_cyc;
  assign wbs_stb_o = r_cyc;
  assign wbs_we_o  = r_we;
  assign wbs_sel_o = r_sel;
  assign wbs_adr_o = r_adr;
  assign wbs_dat_o = r_wdat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed plus randomized checks of wb_cmd_initiator against a transaction-level
// model: stb length, latency, response data/error, hold behaviour and reset abort.
module tb_wb_cmd_initiator;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;

  int checks   = 0;
  int failures = 0;

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command; responder acks after `waits` wait states (>= TO means never in time).
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rdata, input int waits,
                         input int hold, input bit spur);
    int          stb_cnt;
    int          edges;
    bit          done;
    bit          exp_err;
    int          exp_stb;
    logic [31:0] exp_dat;
    exp_err = (waits >= int'(TO));
    exp_stb = exp_err ? int'(TO) : waits + 1;
    exp_dat = (exp_err || we) ? 32'h0 : rdata;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    cmd_we = ~we;

    stb_cnt = 0; edges = 0; done = 1'b0;
    while (!done && edges < 60) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (wbs_stb_o) begin
          stb_cnt++;
          wbs_ack_i = (stb_cnt == waits + 1);
          wbs_dat_i = wbs_ack_i ? rdata : $urandom;
          if (stb_cnt == 1) begin
            chk("bus_we",  32'(wbs_we_o), 32'(we));
            chk("bus_adr", wbs_adr_o, adr);
            chk("bus_dat", wbs_dat_o, dat);
            chk("bus_sel", 32'(wbs_sel_o), 32'(sel));
          end
          chk("bus_cyc", 32'(wbs_cyc_o), 32'd1);
        end else begin
          wbs_ack_i = 1'b0;
        end
        @(posedge clk);
        edges++;
      end
    end
    wbs_ack_i = 1'b0;
    chk("rsp_within_bound", 32'(done), 32'd1);
    chk("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
    chk("rsp_latency", 32'(edges), 32'(exp_stb));
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("cyc_dropped", 32'({wbs_cyc_o, wbs_stb_o}), 32'd0);

    for (int h = 0; h < hold; h++) begin
      wbs_ack_i = spur ? 1'($urandom) : 1'b0;
      wbs_dat_i = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_cyc", 32'(wbs_cyc_o), 32'd0);
    end
    wbs_ack_i = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_consumed", 32'(rsp_valid), 32'd0);
    chk("back_to_idle", 32'(cmd_ready), 32'd1);
    chk("sticky_adr", wbs_adr_o, adr);
    chk("sticky_dat", wbs_dat_o, dat);
    chk("sticky_we_sel", 32'({wbs_we_o, wbs_sel_o}), 32'({we, sel}));
  endtask

  initial begin
    int          rises[$];
    logic [31:0] b2b_adr[4];
    int          idx;
    int          nresp;
    logic        cyc_prev;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; wbs_ack_i = 1'b0; wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_cyc_stb", 32'({wbs_cyc_o, wbs_stb_o}), 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    chk("reset_rsp_dat", rsp_dat, 32'h0);
    chk("reset_bus_regs", wbs_adr_o | wbs_dat_o | 32'(wbs_sel_o) | 32'(wbs_we_o), 32'h0);
    rst_n = 1'b1;

    run_txn(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 32'h1234_5678, 0, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, 3, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hCAFE_F00D, 1000, 0, 1'b0);
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 32'h0BAD_CAFE, int'(TO) - 1, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h5555_AAAA, 2, 5, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
              int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset asserted for one edge during the second stb cycle of a read.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_stb", 32'(wbs_stb_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset_cyc_stb", 32'({wbs_cyc_o, wbs_stb_o}), 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    wbs_ack_i = 1'b0;
    chk("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_ack_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("late_ack_cmd_ready", 32'(cmd_ready), 32'd1);

    // Four back-to-back writes with a zero-wait responder and rsp_ready tied high.
    for (int k = 0; k < 4; k++) b2b_adr[k] = 32'h3000_0100 + 32'(k * 4);
    rsp_ready = 1'b1; idx = 0; nresp = 0; cyc_prev = 1'b0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      @(negedge clk);
      wbs_ack_i = wbs_stb_o;
      if (rsp_valid) begin
        nresp++;
        chk("b2b_rsp_order", 32'(rises.size()), 32'(nresp));
        chk("b2b_rsp_dat", rsp_dat, 32'h0);
        chk("b2b_rsp_err", 32'(rsp_err), 32'd0);
      end
      if (wbs_cyc_o && !cyc_prev && rises.size() < 4) begin
        chk("b2b_adr", wbs_adr_o, b2b_adr[rises.size()]);
        chk("b2b_dat", wbs_dat_o, ~b2b_adr[rises.size()]);
        rises.push_back(c);
      end
      cyc_prev = wbs_cyc_o;
      if (cmd_ready) begin
        if (idx < 4) begin
          cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF;
          cmd_adr = b2b_adr[idx]; cmd_dat = ~b2b_adr[idx];
          idx++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0; wbs_ack_i = 1'b0;
    chk("b2b_resp_count", 32'(nresp), 32'd4);
    chk("b2b_cyc_count", 32'(rises.size()), 32'd4);
    for (int k = 1; k < rises.size(); k++) begin
      chk("b2b_spacing", 32'(rises[k] - rises[k-1]), 32'd3);
    end
    chk("b2b_idle_after", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
